// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types for the memory-port arbiter: the 16-bit core
//               word, the kind of an in-flight memory operation, the tag
//               carried down the latency pipeline, and a helper that applies
//               a branch flush to a single tag.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int c_word_w = 16;

    typedef logic [c_word_w-1:0] word_t;

    typedef enum logic [1:0] {
        MK_NONE  = 2'd0,
        MK_FETCH = 2'd1,
        MK_LOAD  = 2'd2,
        MK_STORE = 2'd3
    } mem_kind_e;

    typedef struct packed {
        logic      valid;
        mem_kind_e kind;
    } mem_tag_t;

    // A taken branch makes every in-flight fetch useless; data operations
    // must still complete, so only FETCH tags are dropped.
    function automatic mem_tag_t tag_after_flush(input mem_tag_t t, input logic flush);
        mem_tag_t r;
        r = t;
        if (flush && (t.kind == MK_FETCH)) begin
            r = '0;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mem_tag_pipe
// Description : MEM_LAT-stage shift register of {valid, kind} tags. A tag
//               entering in cycle N is presented at the tail in cycle
//               N+MEM_LAT. A flush drops FETCH tags from every stage at the
//               clock edge and suppresses a FETCH tail combinationally.
// Ports       : clk     - clock
//               reset   - asynchronous active-high reset, clears all stages
//               flush   - kill in-flight FETCH tags
//               in_tag  - tag of the operation issued this cycle
//               tail    - tag whose memory response is due this cycle
//               busy    - any stage holds a valid tag
// Revision    : 1.0 - initial release
// ============================================================================
module mem_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     flush,
    input  mem_tag_t in_tag,
    output mem_tag_t tail,
    output logic     busy
);

    mem_tag_t r_stage    [MEM_LAT];
    mem_tag_t w_stage_in [MEM_LAT];

    genvar gi;
    generate
        for (gi = 0; gi < MEM_LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign w_stage_in[gi] = in_tag;
            end else begin : g_body
                assign w_stage_in[gi] = r_stage[gi-1];
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_stage[gi] <= '0;
                end else begin
                    r_stage[gi] <= tag_after_flush(w_stage_in[gi], flush);
                end
            end
        end
    endgenerate

    // The tail is consumed this cycle, so a flush has to hide it now rather
    // than at the next edge.
    assign tail = tag_after_flush(r_stage[MEM_LAT-1], flush);

    // Raw stage occupancy: a FETCH about to be flushed still counts as in
    // flight until the edge that removes it.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < MEM_LAT; i++) begin
            busy = busy | r_stage[i].valid;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one fixed-latency memory port between the instruction
//               fetch requester and the load/store requester. At most one
//               request is issued per cycle; the kind of each issued request
//               travels down a MEM_LAT-stage tag pipeline so the response
//               can be routed back to its requester. A branch flush kills
//               in-flight fetches.
// Config      : MEM_PORT_ARB_RR_EN - when defined, contested cycles use
//               strict round-robin; otherwise data has priority and a
//               starvation counter forces a fetch win after STARVE_LIM
//               consecutive contested losses.
// Ports       : clk, reset                 - clock, async active-high reset
//               if_req_valid/addr/ready    - fetch request handshake
//               d_req_valid/we/addr/wdata  - data request (we=1 store)
//               d_req_ready                - data granted this cycle
//               flush                      - branch taken, kill fetches
//               mem_req_valid/we/addr/wdata- request to memory
//               mem_rdata                  - read data, MEM_LAT after issue
//               if_resp_valid              - fetch response
//               d_resp_valid               - load data / store acknowledge
//               resp_rdata                 - response data (0 for stores)
//               busy                       - any operation in flight
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_valid,
    input  logic [15:0] if_req_addr,
    output logic        if_req_ready,
    input  logic        d_req_valid,
    input  logic        d_req_we,
    input  logic [15:0] d_req_addr,
    input  logic [15:0] d_req_wdata,
    output logic        d_req_ready,
    input  logic        flush,
    output logic        mem_req_valid,
    output logic        mem_req_we,
    output logic [15:0] mem_req_addr,
    output logic [15:0] mem_req_wdata,
    input  logic [15:0] mem_rdata,
    output logic        if_resp_valid,
    output logic        d_resp_valid,
    output logic [15:0] resp_rdata,
    output logic        busy
);

    import mem_arb_pkg::*;

    logic     w_if_elig;
    logic     w_d_elig;
    logic     w_contested;
    logic     w_fetch_pri;
    logic     w_fetch_win;
    logic     w_data_win;
    mem_tag_t w_issue_tag;
    mem_tag_t w_tail;

    // A fetch in a flush cycle is for the wrong path and must not issue.
    assign w_if_elig   = if_req_valid && !flush && !reset;
    assign w_d_elig    = d_req_valid && !reset;
    assign w_contested = w_if_elig && w_d_elig;

`ifdef MEM_PORT_ARB_RR_EN
    // Remembers who won the last contested cycle. Resetting to "fetch"
    // makes data win the first contest.
    logic r_last_fetch;

    assign w_fetch_pri = !r_last_fetch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_fetch <= 1'b1;
        end else if (w_contested) begin
            r_last_fetch <= w_fetch_win;
        end
    end
`else
    localparam int c_starve_w = $clog2(STARVE_LIM + 1);

    logic [c_starve_w-1:0] r_starve_cnt;

    assign w_fetch_pri = (r_starve_cnt == c_starve_w'(STARVE_LIM));

    // Once the count reaches the limit fetch wins the next contest and the
    // count clears, so the increment never runs past STARVE_LIM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_fetch_win) begin
            r_starve_cnt <= '0;
        end else if (w_contested) begin
            r_starve_cnt <= r_starve_cnt + c_starve_w'(1);
        end
    end
`endif

    assign w_fetch_win = w_if_elig && (!w_d_elig || w_fetch_pri);
    assign w_data_win  = w_d_elig && !w_fetch_win;

    assign if_req_ready  = w_fetch_win;
    assign d_req_ready   = w_data_win;
    assign mem_req_valid = w_fetch_win || w_data_win;
    assign mem_req_we    = w_data_win && d_req_we;
    assign mem_req_wdata = (w_data_win && d_req_we) ? d_req_wdata : 16'h0000;

    always_comb begin
        mem_req_addr = 16'h0000;
        if (w_fetch_win) begin
            mem_req_addr = if_req_addr;
        end else if (w_data_win) begin
            mem_req_addr = d_req_addr;
        end
    end

    always_comb begin
        w_issue_tag = '0;
        if (w_fetch_win) begin
            w_issue_tag.valid = 1'b1;
            w_issue_tag.kind  = MK_FETCH;
        end else if (w_data_win) begin
            w_issue_tag.valid = 1'b1;
            w_issue_tag.kind  = d_req_we ? MK_STORE : MK_LOAD;
        end
    end

    mem_tag_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_tag_pipe (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .in_tag (w_issue_tag),
        .tail   (w_tail),
        .busy   (busy)
    );

    assign if_resp_valid = w_tail.valid && (w_tail.kind == MK_FETCH);
    assign d_resp_valid  = w_tail.valid &&
                           ((w_tail.kind == MK_LOAD) || (w_tail.kind == MK_STORE));
    assign resp_rdata    = (w_tail.valid &&
                            ((w_tail.kind == MK_FETCH) || (w_tail.kind == MK_LOAD)))
                           ? mem_rdata : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A cycle-level
//               reference model keeps a calendar of expected responses
//               indexed by due cycle, plus the arbitration history.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_LIM = 4;
    localparam int CAL        = 64;

    localparam logic [1:0] K_NONE  = 2'd0;
    localparam logic [1:0] K_FETCH = 2'd1;
    localparam logic [1:0] K_LOAD  = 2'd2;
    localparam logic [1:0] K_STORE = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req_valid = 1'b0;
    logic [15:0] if_req_addr = 16'h0;
    logic        if_req_ready;
    logic        d_req_valid = 1'b0;
    logic        d_req_we = 1'b0;
    logic [15:0] d_req_addr = 16'h0;
    logic [15:0] d_req_wdata = 16'h0;
    logic        d_req_ready;
    logic        flush = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_we;
    logic [15:0] mem_req_addr;
    logic [15:0] mem_req_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic        if_resp_valid;
    logic        d_resp_valid;
    logic [15:0] resp_rdata;
    logic        busy;

    mem_port_arbiter #(
        .MEM_LAT    (MEM_LAT),
        .STARVE_LIM (STARVE_LIM)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .if_req_valid  (if_req_valid),
        .if_req_addr   (if_req_addr),
        .if_req_ready  (if_req_ready),
        .d_req_valid   (d_req_valid),
        .d_req_we      (d_req_we),
        .d_req_addr    (d_req_addr),
        .d_req_wdata   (d_req_wdata),
        .d_req_ready   (d_req_ready),
        .flush         (flush),
        .mem_req_valid (mem_req_valid),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_rdata     (mem_rdata),
        .if_resp_valid (if_resp_valid),
        .d_resp_valid  (d_resp_valid),
        .resp_rdata    (resp_rdata),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: response calendar, contest history.
    logic [1:0] cal [CAL];
    int         cyc        = 0;
    int         starve     = 0;
    bit         last_fetch = 1'b1;
    logic       seen_if_ready;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < CAL; i++) cal[i] = K_NONE;
        starve     = 0;
        last_fetch = 1'b1;
    endtask

    // Called at a negedge with inputs already driven; checks this cycle,
    // advances the model, returns at the next negedge.
    task automatic step(output bit fw, output bit dw);
        bit         fe, de, ebusy;
        logic [1:0] due;
        logic [15:0] eaddr, erd;
        mem_rdata = 16'($urandom);
        #1;
        fe = if_req_valid && !flush;
        de = d_req_valid;
        if (fe && de) begin
`ifdef MEM_PORT_ARB_RR_EN
            fw = !last_fetch;
`else
            fw = (starve >= STARVE_LIM);
`endif
        end else begin
            fw = fe;
        end
        dw = de && !fw;

        ebusy = 1'b0;
        for (int k = 0; k < MEM_LAT; k++)
            if (cal[(cyc + k) % CAL] != K_NONE) ebusy = 1'b1;
        due = cal[cyc % CAL];
        if (flush && due == K_FETCH) due = K_NONE;
        erd   = (due == K_FETCH || due == K_LOAD) ? mem_rdata : 16'h0000;
        eaddr = fw ? if_req_addr : d_req_addr;

        seen_if_ready = if_req_ready;
        chk("if_req_ready", {15'b0, if_req_ready}, {15'b0, fw});
        chk("d_req_ready", {15'b0, d_req_ready}, {15'b0, dw});
        chk("mem_req_valid", {15'b0, mem_req_valid}, {15'b0, fw | dw});
        chk("mem_req_we", {15'b0, mem_req_we}, {15'b0, dw & d_req_we});
        chk("mem_req_wdata", mem_req_wdata, (dw && d_req_we) ? d_req_wdata : 16'h0000);
        if (fw || dw) chk("mem_req_addr", mem_req_addr, eaddr);
        chk("if_resp_valid", {15'b0, if_resp_valid}, {15'b0, due == K_FETCH});
        chk("d_resp_valid", {15'b0, d_resp_valid},
            {15'b0, (due == K_LOAD) || (due == K_STORE)});
        chk("resp_rdata", resp_rdata, erd);
        chk("busy", {15'b0, busy}, {15'b0, ebusy});

        cal[cyc % CAL] = K_NONE;
        if (flush)
            for (int k = 1; k < MEM_LAT; k++)
                if (cal[(cyc + k) % CAL] == K_FETCH) cal[(cyc + k) % CAL] = K_NONE;
        cal[(cyc + MEM_LAT) % CAL] = fw ? K_FETCH : (dw ? (d_req_we ? K_STORE : K_LOAD) : K_NONE);
        if (fw) starve = 0;
        else if (fe && de) starve = starve + 1;
        if (fe && de) last_fetch = fw;
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_if_ready"}, {15'b0, if_req_ready}, 16'h0);
        chk({tag, "_d_ready"}, {15'b0, d_req_ready}, 16'h0);
        chk({tag, "_mem_valid"}, {15'b0, mem_req_valid}, 16'h0);
        chk({tag, "_mem_we"}, {15'b0, mem_req_we}, 16'h0);
        chk({tag, "_mem_addr"}, mem_req_addr, 16'h0);
        chk({tag, "_mem_wdata"}, mem_req_wdata, 16'h0);
        chk({tag, "_if_resp"}, {15'b0, if_resp_valid}, 16'h0);
        chk({tag, "_d_resp"}, {15'b0, d_resp_valid}, 16'h0);
        chk({tag, "_rdata"}, resp_rdata, 16'h0);
        chk({tag, "_busy"}, {15'b0, busy}, 16'h0);
    endtask

    // Asserted mid-cycle (no edge) with requests pending, to expose async
    // clearing and ready gating.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check_all_zero(tag);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle_in();
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        d_req_we     = 1'b0;
        flush        = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit fw, dw;
        bit pf, pd;
        model_clear();
        @(negedge clk);
        if_req_valid = 1'b1;
        d_req_valid  = 1'b1;
        #1;
        check_all_zero("rst_init");
        @(negedge clk);
        idle_in();
        reset = 1'b0;

        // 1: single fetch, response MEM_LAT later
        if_req_valid = 1'b1; if_req_addr = 16'h0000;
        step(fw, dw);
        idle_in();
        repeat (3) step(fw, dw);

        // 2: contested cycle, data load wins then fetch
        if_req_valid = 1'b1; if_req_addr = 16'h0002;
        d_req_valid = 1'b1; d_req_addr = 16'h0020;
        step(fw, dw);
        chk("t2_fetch_lost", {15'b0, seen_if_ready}, 16'h0);
        d_req_valid = 1'b0;
        step(fw, dw);
        if_req_valid = 1'b0;
        repeat (3) step(fw, dw);

        // 3: continuous contention from a clean state
        do_reset("rst_t3");
        if_req_valid = 1'b1; if_req_addr = 16'h0100;
        d_req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d_req_addr = 16'h0200 + 16'(i);
            step(fw, dw);
`ifdef MEM_PORT_ARB_RR_EN
            chk("t3_order", {15'b0, seen_if_ready}, {15'b0, (i % 2) == 1});
`else
            chk("t3_order", {15'b0, seen_if_ready}, {15'b0, (i % 5) == 4});
`endif
        end
        idle_in();
        repeat (3) step(fw, dw);

        // 4: two fetches then flush with a load in the flush cycle
        if_req_valid = 1'b1; if_req_addr = 16'h0300;
        step(fw, dw);
        if_req_addr = 16'h0302;
        step(fw, dw);
        flush = 1'b1; d_req_valid = 1'b1; d_req_addr = 16'h0030;
        step(fw, dw);
        idle_in();
        repeat (3) step(fw, dw);

        // 5: store, acknowledged with zero data
        d_req_valid = 1'b1; d_req_we = 1'b1;
        d_req_addr = 16'h0040; d_req_wdata = 16'hBEEF;
        step(fw, dw);
        idle_in();
        repeat (3) step(fw, dw);

        // 6: load then asynchronous reset while it is in flight
        d_req_valid = 1'b1; d_req_addr = 16'h0050;
        step(fw, dw);
        if_req_valid = 1'b1; d_req_valid = 1'b1;
        do_reset("rst_t6");
        idle_in();
        repeat (3) step(fw, dw);

        // Randomised traffic with held requests, flushes and rare resets
        pf = 1'b0; pd = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!pf && ($urandom_range(0, 1) == 1)) begin
                pf = 1'b1; if_req_addr = 16'($urandom);
            end
            if (!pd && ($urandom_range(0, 1) == 1)) begin
                pd = 1'b1; d_req_addr = 16'($urandom);
                d_req_we = 1'($urandom); d_req_wdata = 16'($urandom);
            end
            if_req_valid = pf;
            d_req_valid  = pd;
            flush        = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 149) == 0) begin
                do_reset("rst_rand");
                pf = 1'b0; pd = 1'b0;
                idle_in();
            end else begin
                step(fw, dw);
                if (fw) pf = 1'b0;
                if (dw) pd = 1'b0;
            end
        end
        idle_in();
        repeat (3) step(fw, dw);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
